// File: rtl/lfsr_64_pkg.sv
// Shared LFSR-64 definitions: x^64+x^63+x^61+x^60+1 Fibonacci step.
// Reused by the checker and, later, by the generator.
package lfsr_64_pkg;

    localparam int LFSR_W = 64;

    localparam int TAP_A = 63;
    localparam int TAP_B = 62;
    localparam int TAP_C = 60;
    localparam int TAP_D = 59;

    localparam logic [LFSR_W-1:0] LFSR_SEED = '1;

    typedef enum logic [1:0] {
        SEED,
        HUNT,
        LOCKED
    } chk_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_64_step(
        input logic [LFSR_W-1:0] v
    );
        return {v[LFSR_W-2:0], v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D]};
    endfunction

endpackage

// File: rtl/lfsr_64_chk_popcount_64.sv
// Adder-tree popcount of a 64-bit word; the sum feeds a registered
// accumulator in the checker (used only with LFSR_CHK_BITERR_EN).
module popcount_64 (
    input  logic [63:0] i_data,
    output logic [6:0]  o_count
);

    logic [1:0] w_s1 [32];
    logic [2:0] w_s2 [16];
    logic [3:0] w_s3 [8];
    logic [4:0] w_s4 [4];
    logic [5:0] w_s5 [2];

    always_comb begin
        for (int i = 0; i < 32; i++)
            w_s1[i] = {1'b0, i_data[2*i]} + {1'b0, i_data[2*i+1]};
        for (int i = 0; i < 16; i++)
            w_s2[i] = {1'b0, w_s1[2*i]} + {1'b0, w_s1[2*i+1]};
        for (int i = 0; i < 8; i++)
            w_s3[i] = {1'b0, w_s2[2*i]} + {1'b0, w_s2[2*i+1]};
        for (int i = 0; i < 4; i++)
            w_s4[i] = {1'b0, w_s3[2*i]} + {1'b0, w_s3[2*i+1]};
        for (int i = 0; i < 2; i++)
            w_s5[i] = {1'b0, w_s4[2*i]} + {1'b0, w_s4[2*i+1]};
        o_count = {1'b0, w_s5[0]} + {1'b0, w_s5[1]};
    end

endmodule

// File: rtl/lfsr_64_chk.sv
// Self-synchronising LFSR-64 stream checker: SEED -> HUNT -> LOCKED.
// Optional LFSR_CHK_BITERR_EN adds a saturating bit-error counter.
module lfsr_64_chk
    import lfsr_64_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [LFSR_W-1:0] in_data,
    output logic              locked,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  word_cnt,
`ifdef LFSR_CHK_BITERR_EN
    output logic [CNT_W-1:0]  bit_err_cnt,
`endif
    output logic [CNT_W-1:0]  err_word_cnt
);

    localparam logic [7:0] LOCK_N   = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_CNT);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    chk_state_t        r_state;
    logic [LFSR_W-1:0] r_ref;
    logic [7:0]        r_match_run;
    logic [7:0]        r_miss_run;
    logic              r_locked;
    logic              r_err_pulse;
    logic [CNT_W-1:0]  r_word_cnt;
    logic [CNT_W-1:0]  r_err_cnt;

    logic [LFSR_W-1:0] w_pred;
    logic              w_match;
    logic              w_nz;
    logic [7:0]        w_match_inc;
    logic [7:0]        w_miss_inc;

    assign w_pred      = lfsr_64_step(r_ref);
    assign w_match     = (in_data == w_pred);
    assign w_nz        = |in_data;
    assign w_match_inc = r_match_run + 8'd1;
    assign w_miss_inc  = r_miss_run + 8'd1;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + ONE;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= SEED;
            r_ref       <= '0;
            r_match_run <= '0;
            r_miss_run  <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_word_cnt  <= '0;
            r_err_cnt   <= '0;
        end else if (clear) begin
            r_state     <= SEED;
            r_match_run <= '0;
            r_miss_run  <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_word_cnt  <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            if (in_valid) begin
                unique case (r_state)
                    SEED: begin
                        // all-zero is the LFSR lock-up word, never a seed
                        if (w_nz) begin
                            r_ref       <= in_data;
                            r_match_run <= '0;
                            r_state     <= HUNT;
                        end
                    end
                    HUNT: begin
                        if (w_match) begin
                            r_ref       <= in_data;
                            r_match_run <= w_match_inc;
                            if (w_match_inc == LOCK_N) begin
                                r_state    <= LOCKED;
                                r_locked   <= 1'b1;
                                r_miss_run <= '0;
                            end
                        end else begin
                            r_match_run <= '0;
                            if (w_nz) r_ref <= in_data;
                            else r_state <= SEED;
                        end
                    end
                    LOCKED: begin
                        // free-run the prediction so one bad word
                        // does not poison the next
                        r_ref      <= w_pred;
                        r_word_cnt <= sat_inc(r_word_cnt);
                        if (w_match) begin
                            r_miss_run <= '0;
                        end else begin
                            r_err_cnt   <= sat_inc(r_err_cnt);
                            r_err_pulse <= 1'b1;
                            r_miss_run  <= w_miss_inc;
                            if (w_miss_inc == UNLOCK_N) begin
                                r_state     <= HUNT;
                                r_locked    <= 1'b0;
                                r_ref       <= in_data;
                                r_match_run <= '0;
                            end
                        end
                    end
                    default: begin
                        r_state  <= SEED;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked       = r_locked;
    assign err_pulse    = r_err_pulse;
    assign word_cnt     = r_word_cnt;
    assign err_word_cnt = r_err_cnt;

`ifdef LFSR_CHK_BITERR_EN
    logic [6:0]       w_pop;
    logic [CNT_W:0]   w_bit_sum;
    logic [CNT_W-1:0] r_bit_err_cnt;

    popcount_64 u_pop (
        .i_data  (in_data ^ w_pred),
        .o_count (w_pop)
    );

    assign w_bit_sum = {1'b0, r_bit_err_cnt} + (CNT_W+1)'(w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_bit_err_cnt <= '0;
        end else if (in_valid && r_state == LOCKED) begin
            r_bit_err_cnt <= w_bit_sum[CNT_W] ? '1 : w_bit_sum[CNT_W-1:0];
        end
    end

    assign bit_err_cnt = r_bit_err_cnt;
`endif

endmodule

// File: tb/tb_lfsr_64_chk.sv
// Directed + random bench for lfsr_64_chk against a behavioural model.
// Build with LFSR_CHK_BITERR_EN to cover the bit-error counter too.
module tb_lfsr_64_chk;

    localparam int CW     = 8;
    localparam int MAXC   = (1 << CW) - 1;
    localparam int LOCKN  = 4;
    localparam int ULOCKN = 3;
    localparam logic [63:0] TAPMASK = 64'hD800_0000_0000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [63:0]   in_data = '0;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] word_cnt;
    logic [CW-1:0] err_word_cnt;
`ifdef LFSR_CHK_BITERR_EN
    logic [CW-1:0] bit_err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_64_chk #(
        .LOCK_CNT   (LOCKN),
        .UNLOCK_CNT (ULOCKN),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .word_cnt     (word_cnt),
`ifdef LFSR_CHK_BITERR_EN
        .bit_err_cnt  (bit_err_cnt),
`endif
        .err_word_cnt (err_word_cnt)
    );

    typedef enum {M_SEED, M_HUNT, M_LOCK} mst_t;
    mst_t        m_st = M_SEED;
    logic [63:0] m_ref = '0;
    int          m_mr = 0, m_ms = 0;
    int          m_wc = 0, m_ec = 0, m_bc = 0;
    bit          m_pulse = 0;
    logic [63:0] g = '1;

    // polynomial as a parity over the tap mask
    function automatic logic [63:0] adv(input logic [63:0] w);
        return (w << 1) | 64'(^(w & TAPMASK));
    endfunction

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic model(input bit rs, input bit clr,
                         input bit v, input logic [63:0] d);
        logic [63:0] p;
        m_pulse = 0;
        if (rs) begin
            m_st = M_SEED; m_ref = '0; m_mr = 0; m_ms = 0;
            m_wc = 0; m_ec = 0; m_bc = 0;
        end else if (clr) begin
            m_st = M_SEED; m_mr = 0; m_ms = 0;
            m_wc = 0; m_ec = 0; m_bc = 0;
        end else if (v) begin
            p = adv(m_ref);
            case (m_st)
                M_SEED: if (d != 0) begin
                    m_ref = d; m_mr = 0; m_st = M_HUNT;
                end
                M_HUNT: if (d == p) begin
                    m_ref = d; m_mr++;
                    if (m_mr == LOCKN) begin m_st = M_LOCK; m_ms = 0; end
                end else begin
                    m_mr = 0;
                    if (d != 0) m_ref = d; else m_st = M_SEED;
                end
                default: begin
                    m_wc = sat(m_wc + 1);
                    m_bc = sat(m_bc + $countones(d ^ p));
                    m_ref = p;
                    if (d == p) m_ms = 0;
                    else begin
                        m_ec = sat(m_ec + 1); m_pulse = 1; m_ms++;
                        if (m_ms == ULOCKN) begin
                            m_st = M_HUNT; m_ref = d; m_mr = 0;
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit v, input logic [63:0] d,
                       input bit clr, input bit rs);
        in_valid = v; in_data = d; clear = clr; rst_n = !rs;
        @(posedge clk);
        #1;
        model(rs, clr, v, d);
        chk("locked", 64'(locked), 64'(m_st == M_LOCK));
        chk("err_pulse", 64'(err_pulse), 64'(m_pulse));
        chk("word_cnt", 64'(word_cnt), 64'(m_wc));
        chk("err_word_cnt", 64'(err_word_cnt), 64'(m_ec));
`ifdef LFSR_CHK_BITERR_EN
        chk("bit_err_cnt", 64'(bit_err_cnt), 64'(m_bc));
`endif
    endtask

    task automatic word(input logic [63:0] mask);
        cyc(1'b1, g ^ mask, 1'b0, 1'b0);
        g = adv(g);
    endtask

    logic [63:0] fmask;
    logic [63:0] rmask;

    initial begin
        cyc(0, '0, 0, 1);
        cyc(0, '0, 0, 1);
        chk("rst_locked", 64'(locked), 64'(0));
        chk("rst_word_cnt", 64'(word_cnt), 64'(0));

        repeat (5) cyc(1, '0, 0, 0);
        chk("zero_locked", 64'(locked), 64'(0));
        chk("zero_err_cnt", 64'(err_word_cnt), 64'(0));

        g = '1;
        for (int k = 1; k <= 10; k++) begin
            word('0);
            if (k == 4) chk("acq_w4_unlocked", 64'(locked), 64'(0));
            if (k == 5) chk("acq_w5_locked", 64'(locked), 64'(1));
        end
        chk("acq_word_cnt", 64'(word_cnt), 64'(5));
        chk("acq_err_cnt", 64'(err_word_cnt), 64'(0));

        repeat (9) word('0);
`ifdef LFSR_CHK_BITERR_EN
        fmask = (64'd1 << 63) | (64'd1 << 5) | 64'd1;
`else
        fmask = 64'd1;
`endif
        word(fmask);
        chk("single_pulse", 64'(err_pulse), 64'(1));
        chk("single_locked", 64'(locked), 64'(1));
        word('0);
        chk("single_pulse_off", 64'(err_pulse), 64'(0));
        chk("single_err_cnt", 64'(err_word_cnt), 64'(1));
        chk("single_word_cnt", 64'(word_cnt), 64'(16));
`ifdef LFSR_CHK_BITERR_EN
        chk("single_bit_err", 64'(bit_err_cnt), 64'(3));
`endif

        word(64'h80);
        word(64'h80);
        chk("lose_w2_locked", 64'(locked), 64'(1));
        word(64'h80);
        chk("lose_w3_unlocked", 64'(locked), 64'(0));
        chk("lose_err_cnt", 64'(err_word_cnt), 64'(4));
        for (int k = 1; k <= 5; k++) begin
            word('0);
            if (k == 4) chk("relock_w4", 64'(locked), 64'(0));
            if (k == 5) chk("relock_w5", 64'(locked), 64'(1));
        end

        for (int k = 0; k < 6; k++) begin
            word('0);
            repeat (7) cyc(0, $urandom, 0, 0);
        end
        chk("gap_word_cnt", 64'(word_cnt), 64'(25));
        chk("gap_err_cnt", 64'(err_word_cnt), 64'(4));

        g = '1;
        for (int k = 1; k <= 7; k++) begin
            word('0);
            if (k == 6) chk("restart_w6", 64'(locked), 64'(0));
            if (k == 7) chk("restart_w7", 64'(locked), 64'(1));
        end

        cyc(1, g, 1, 0);
        g = adv(g);
        chk("clr_locked", 64'(locked), 64'(0));
        chk("clr_word_cnt", 64'(word_cnt), 64'(0));
        chk("clr_err_cnt", 64'(err_word_cnt), 64'(0));
        word('0);
        chk("clr_seed_cnt", 64'(word_cnt), 64'(0));
        repeat (4) word('0);
        chk("clr_relock", 64'(locked), 64'(1));

        for (int k = 0; k < 500; k++) begin
            rmask = '0;
            if ($urandom_range(0, 7) == 0)
                rmask = 64'd1 << $urandom_range(0, 63);
            if ($urandom_range(0, 149) == 0) g = '1;
            if ($urandom_range(0, 99) == 0)
                cyc(1, g, 1, 0);
            else if ($urandom_range(0, 3) == 0)
                cyc(0, $urandom, 0, 0);
            else
                word(rmask);
        end

        cyc(0, '0, 1, 0);
        repeat (5) word('0);
        for (int k = 0; k < 600; k++) word((k % 2) ? 64'd1 : 64'd0);
        chk("sat_word_cnt", 64'(word_cnt), 64'(MAXC));
        chk("sat_err_cnt", 64'(err_word_cnt), 64'(MAXC));
        chk("sat_locked", 64'(locked), 64'(1));

        cyc(1, g, 0, 1);
        chk("midrst_locked", 64'(locked), 64'(0));
        chk("midrst_word_cnt", 64'(word_cnt), 64'(0));
        cyc(0, '0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
